// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock: FSM states, comparison selectors,
// blink patterns and default key codes.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_UC  = 3'd0,
    ST_ENTER_PC  = 3'd1,
    ST_ENTER_NEW = 3'd2,
    ST_BLINK     = 3'd3,
    ST_UNLOCKED  = 3'd4,
    ST_LOCKOUT   = 3'd5
  } state_t;

  localparam logic [1:0] CMP_UC  = 2'b01;
  localparam logic [1:0] CMP_PC  = 2'b11;
  localparam logic [1:0] CMP_NEW = 2'b10;

  localparam logic BLINK_OK   = 1'b0;
  localparam logic BLINK_FAIL = 1'b1;

  localparam logic [3:0] DEF_KEY_MODE   = 4'd8;
  localparam logic [3:0] DEF_KEY_CANCEL = 4'd9;

endpackage

// File: rtl/key_event.sv
// Key release detector: one-cycle key_evt on a registered falling edge of bstate,
// with the key code captured while the key is held.
module key_event (
  input  logic       clk,
  input  logic       rst,
  input  logic       bstate,
  input  logic [3:0] button,
  output logic       key_evt,
  output logic [3:0] key_code
);

  logic bstate_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate_prev <= 1'b0;
      key_evt     <= 1'b0;
      key_code    <= 4'd0;
    end else begin
      bstate_prev <= bstate;
      key_evt     <= bstate_prev & ~bstate;
      if (bstate) key_code <= button;
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Central sequencing FSM for the keypad lock: mode selection, blink triggering,
// new-code commit, auto-relock and failed-attempt lockout.
//
// state        | meaning
// ENTER_UC     | waiting for user code
// ENTER_PC     | waiting for programming code
// ENTER_NEW    | capturing a new user code
// BLINK        | blinker running; next state held in after_q
// UNLOCKED     | open, relock timer running
// LOCKOUT      | too many failures, lockout timer running
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [23:0] RELOCK_CYCLES  = 24'd12_000_000,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000,
  parameter int          MAX_FAILS      = 3,
  parameter logic [3:0]  KEY_MODE       = DEF_KEY_MODE,
  parameter logic [3:0]  KEY_CANCEL     = DEF_KEY_CANCEL
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       bstate,
  input  logic [3:0] button,
  input  logic       data_ready,
  input  logic       correct_input,
  input  logic       done_blinking,
  output logic       read_input,
  output logic [1:0] compare_type,
  output logic       start_blinking,
  output logic       blink_type,
  output logic       store,
  output logic       led_unlocked,
  output logic       led_prog,
  output logic       led_lockout
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

  state_t        state, state_d, after_q, after_d, go_after;
  logic [FW-1:0] fail_cnt, fail_d, fail_inc;
  logic [23:0]   timer, timer_d;
  logic          blink_type_q, blink_type_d, start_q, start_d, store_q, store_d;
  logic [1:0]    cmp_q, cmp_d;
  logic          key_evt, key_act, go_blink, go_type;
  logic [3:0]    key_code;

  key_event u_key_event (
    .clk      (hwclk),
    .rst      (rst),
    .bstate   (bstate),
    .button   (button),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  assign read_input     = (state != ST_BLINK) && (state != ST_LOCKOUT);
  assign key_act        = key_evt & read_input;
  assign fail_inc       = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + FW'(1);
  assign compare_type   = cmp_q;
  assign start_blinking = start_q;
  assign blink_type     = blink_type_q;
  assign store          = store_q;
  assign led_unlocked   = (state == ST_UNLOCKED);
  assign led_prog       = (state == ST_ENTER_PC) || (state == ST_ENTER_NEW);
  assign led_lockout    = (state == ST_LOCKOUT);

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state        <= ST_ENTER_UC;
      after_q      <= ST_ENTER_UC;
      fail_cnt     <= '0;
      timer        <= '0;
      blink_type_q <= BLINK_OK;
      start_q      <= 1'b0;
      store_q      <= 1'b0;
      cmp_q        <= CMP_UC;
    end else begin
      state        <= state_d;
      after_q      <= after_d;
      fail_cnt     <= fail_d;
      timer        <= timer_d;
      blink_type_q <= blink_type_d;
      start_q      <= start_d;
      store_q      <= store_d;
      cmp_q        <= cmp_d;
    end
  end

  always_comb begin
    state_d      = state;
    after_d      = after_q;
    fail_d       = fail_cnt;
    timer_d      = timer;
    blink_type_d = blink_type_q;
    start_d      = 1'b0;
    store_d      = 1'b0;
    go_blink     = 1'b0;
    go_type      = BLINK_OK;
    go_after     = ST_ENTER_UC;

    case (state)
      ST_ENTER_UC, ST_ENTER_PC: begin
        // A verdict takes priority over any key event in the same cycle.
        if (data_ready) begin
          go_blink = 1'b1;
          if (correct_input) begin
            go_type  = BLINK_OK;
            if (state == ST_ENTER_UC) begin
              fail_d   = '0;
              go_after = ST_UNLOCKED;
            end else begin
              go_after = ST_ENTER_NEW;
            end
          end else begin
            go_type  = BLINK_FAIL;
            fail_d   = fail_inc;
            go_after = (fail_inc == FAIL_LIMIT) ? ST_LOCKOUT : ST_ENTER_UC;
          end
        end else if (key_act) begin
          if (key_code == KEY_CANCEL) state_d = ST_ENTER_UC;
          else if (key_code == KEY_MODE)
            state_d = (state == ST_ENTER_UC) ? ST_ENTER_PC : ST_ENTER_UC;
        end
      end
      ST_ENTER_NEW: begin
        if (data_ready) begin
          go_blink = 1'b1;
          if (correct_input) begin
            store_d  = 1'b1;
            go_type  = BLINK_OK;
            go_after = ST_ENTER_UC;
          end else begin
            go_type  = BLINK_FAIL;
            go_after = ST_ENTER_NEW;
          end
        end else if (key_act && key_code == KEY_CANCEL) begin
          state_d = ST_ENTER_UC;
        end
      end
      ST_BLINK: begin
        if (done_blinking) state_d = after_q;
      end
      ST_UNLOCKED: begin
        if (timer == RELOCK_CYCLES - 24'd1) state_d = ST_ENTER_UC;
        else if (key_act && key_code == KEY_CANCEL) state_d = ST_ENTER_UC;
        else if (key_act) timer_d = '0;
        else timer_d = timer + 24'd1;
      end
      ST_LOCKOUT: begin
        if (timer == LOCKOUT_CYCLES - 24'd1) begin
          state_d = ST_ENTER_UC;
          fail_d  = '0;
        end else begin
          timer_d = timer + 24'd1;
        end
      end
      default: state_d = ST_ENTER_UC;
    endcase

    if (go_blink) begin
      state_d      = ST_BLINK;
      start_d      = 1'b1;
      blink_type_d = go_type;
      after_d      = go_after;
    end

    if (state_d != state) timer_d = '0;

    // The selector holds its last value through BLINK and LOCKOUT.
    case (state_d)
      ST_ENTER_UC, ST_UNLOCKED: cmp_d = CMP_UC;
      ST_ENTER_PC:              cmp_d = CMP_PC;
      ST_ENTER_NEW:             cmp_d = CMP_NEW;
      default:                  cmp_d = cmp_q;
    endcase
  end

endmodule
